// File: rtl/freelist_ckpt_if.sv
// Allocation / retire / checkpoint bundle between rename, ROB and the physical-register free list.
interface freelist_ckpt_if #(
  parameter int WAYS = 2,
  parameter int PRW  = 6,
  parameter int CKW  = 2
);
  logic [WAYS-1:0]     alloc_req;
  logic [WAYS*PRW-1:0] alloc_pr;
  logic                alloc_ok;
  logic [WAYS-1:0]     retire_en;
  logic [WAYS*PRW-1:0] retire_pr;
  logic                ckpt_save;
  logic [CKW-1:0]      ckpt_id;
  logic                recover_en;
  logic [CKW-1:0]      recover_id;
  logic [PRW:0]        count;
  logic                empty;
  logic                almost_empty;
  logic                full;
  logic                error;

  modport master (
    output alloc_req, retire_en, retire_pr, ckpt_save, ckpt_id, recover_en, recover_id,
    input  alloc_pr, alloc_ok, count, empty, almost_empty, full, error
  );

  modport slave (
    input  alloc_req, retire_en, retire_pr, ckpt_save, ckpt_id, recover_en, recover_id,
    output alloc_pr, alloc_ok, count, empty, almost_empty, full, error
  );
endinterface

// File: rtl/freelist_ckpt.sv
// R10K-style physical-register free list: circular FIFO of free tags with WAYS-wide
// all-or-nothing allocation, WAYS-wide retire, and head-pointer branch checkpoints.
module freelist_ckpt #(
  parameter int NPR   = 64,
  parameter int NARCH = 32,
  parameter int PRW   = 6,
  parameter int WAYS  = 2,
  parameter int NCKPT = 4
) (
  input  logic          clk,
  input  logic          reset,
  freelist_ckpt_if.slave fl
);
  localparam int DEPTH = NPR - NARCH;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTRW  = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("freelist_ckpt: NPR-NARCH must be a power of two");
  end
  if (PRW != $clog2(NPR)) begin : g_bad_prw
    $error("freelist_ckpt: PRW must equal clog2(NPR)");
  end

  logic [PRW-1:0]  mem  [DEPTH];
  logic [PTRW-1:0] slot [NCKPT];
  logic [PTRW-1:0] head, tail, cnt;
  logic [PTRW-1:0] pops, pushes, pops_granted, head_adv;
  logic [PTRW:0]   cnt_next;
  logic            grant, overflow, err_q;
  logic [AW-1:0]   rd_idx [WAYS];
  logic [AW-1:0]   wr_idx [WAYS];

  function automatic logic [PTRW-1:0] popcount(input logic [WAYS-1:0] v);
    logic [PTRW-1:0] n;
    n = '0;
    for (int i = 0; i < WAYS; i++) n = n + PTRW'(v[i]);
    return n;
  endfunction

  // Each active lane takes the slot offset by the number of active lanes below it.
  always_comb begin
    logic [AW-1:0] r_off, w_off;
    r_off = '0;
    w_off = '0;
    fl.alloc_pr = '0;
    for (int i = 0; i < WAYS; i++) begin
      rd_idx[i] = head[AW-1:0] + r_off;
      wr_idx[i] = tail[AW-1:0] + w_off;
      fl.alloc_pr[i*PRW +: PRW] = mem[rd_idx[i]];
      r_off = r_off + AW'(fl.alloc_req[i]);
      w_off = w_off + AW'(fl.retire_en[i]);
    end
  end

  always_comb begin
    cnt          = tail - head;
    pops         = popcount(fl.alloc_req);
    pushes       = popcount(fl.retire_en);
    grant        = (pops <= cnt) && !fl.recover_en;
    pops_granted = grant ? pops : '0;
    head_adv     = head + pops_granted;
    cnt_next     = {1'b0, cnt} - {1'b0, pops_granted} + {1'b0, pushes};
    overflow     = cnt_next > (PTRW+1)'(DEPTH);
  end

  // State update: recovery beats both allocation and checkpoint save; overflow drops the whole retire group.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= PTRW'(DEPTH);
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= PRW'(NARCH + i);
      for (int k = 0; k < NCKPT; k++) slot[k] <= '0;
    end else begin
      head <= fl.recover_en ? slot[fl.recover_id] : head_adv;
      if (fl.ckpt_save && !fl.recover_en) slot[fl.ckpt_id] <= head_adv;
      if (overflow) begin
        err_q <= 1'b1;
      end else begin
        tail <= tail + pushes;
        for (int i = 0; i < WAYS; i++)
          if (fl.retire_en[i]) mem[wr_idx[i]] <= fl.retire_pr[i*PRW +: PRW];
      end
    end
  end

  assign fl.alloc_ok     = grant;
  assign fl.count        = (PRW+1)'(cnt);
  assign fl.empty        = (cnt == '0);
  assign fl.almost_empty = (cnt < PTRW'(WAYS));
  assign fl.full         = (cnt == PTRW'(DEPTH));
  assign fl.error        = err_q;
endmodule

// File: tb/tb_freelist_ckpt.sv
// Bench for freelist_ckpt: unbounded-index reference list feeding a scoreboard, a checkpoint vector table,
// and directed sequences for drain, refill, wrap, partial-grant refusal, overflow and reset.
module tb_freelist_ckpt;
  localparam int NPR = 64, NARCH = 32, PRW = 6, WAYS = 2, NCKPT = 4, CKW = 2;
  localparam int DEPTH = NPR - NARCH;
  localparam int HN = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  freelist_ckpt_if #(.WAYS(WAYS), .PRW(PRW), .CKW(CKW)) fl ();
  freelist_ckpt #(.NPR(NPR), .NARCH(NARCH), .PRW(PRW), .WAYS(WAYS), .NCKPT(NCKPT))
    dut (.clk(clk), .reset(reset), .fl(fl));

  typedef struct packed {
    logic                ok;
    logic [WAYS-1:0]     req;
    logic [WAYS*PRW-1:0] pr;
    logic [PRW:0]        cnt;
    logic                empty, ae, full, err;
  } exp_t;

  typedef struct {
    logic [WAYS-1:0] req;
    logic            save;
    logic            rec;
    int              id;
    logic            ok;
    int              cnt;
    int              pr0;
    int              pr1;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  logic [PRW-1:0] hist [HN];
  int m_head, m_tail, m_slot [NCKPT];
  bit m_err;
  int checks = 0, errors = 0;

  logic [WAYS-1:0] l_req, l_ren;
  logic [WAYS*PRW-1:0] l_rpr;
  logic l_save, l_rec, l_ok;
  int l_sid, l_rid;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) hist[i] = PRW'(NARCH + i);
    m_head = 0;
    m_tail = DEPTH;
    for (int k = 0; k < NCKPT; k++) m_slot[k] = 0;
    m_err = 1'b0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    fl.alloc_req = '0; fl.retire_en = '0; fl.retire_pr = '0;
    fl.ckpt_save = 1'b0; fl.ckpt_id = '0; fl.recover_en = 1'b0; fl.recover_id = '0;
  endtask

  task automatic apply(input logic [WAYS-1:0] req, input logic [WAYS-1:0] ren,
                       input logic [WAYS*PRW-1:0] rpr, input logic save, input int sid,
                       input logic rec, input int rid);
    exp_t e;
    int cnt, pops, k;
    fl.alloc_req = req; fl.retire_en = ren; fl.retire_pr = rpr;
    fl.ckpt_save = save; fl.ckpt_id = CKW'(sid); fl.recover_en = rec; fl.recover_id = CKW'(rid);
    l_req = req; l_ren = ren; l_rpr = rpr; l_save = save; l_sid = sid; l_rec = rec; l_rid = rid;
    cnt  = m_tail - m_head;
    pops = $countones(req);
    e.ok = (pops <= cnt) && !rec;
    e.pr = '0;
    k = 0;
    for (int i = 0; i < WAYS; i++)
      if (req[i]) begin
        e.pr[i*PRW +: PRW] = hist[(m_head + k) % HN];
        k++;
      end
    e.req = req; e.cnt = (PRW+1)'(cnt);
    e.empty = (cnt == 0); e.ae = (cnt < WAYS); e.full = (cnt == DEPTH); e.err = m_err;
    l_ok = e.ok;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("alloc_ok", int'(fl.alloc_ok), int'(e.ok));
    chk("count", int'(fl.count), int'(e.cnt));
    chk("empty", int'(fl.empty), int'(e.empty));
    chk("almost_empty", int'(fl.almost_empty), int'(e.ae));
    chk("full", int'(fl.full), int'(e.full));
    chk("error", int'(fl.error), int'(e.err));
    if (e.ok)
      for (int i = 0; i < WAYS; i++)
        if (e.req[i]) chk($sformatf("alloc_pr%0d", i), int'(fl.alloc_pr[i*PRW +: PRW]), int'(e.pr[i*PRW +: PRW]));
  endtask

  task automatic advance();
    int cnt, pops, pushes, nxt;
    @(posedge clk);
    cnt = m_tail - m_head;
    pops = l_ok ? $countones(l_req) : 0;
    pushes = $countones(l_ren);
    nxt = cnt - pops + pushes;
    if (nxt > DEPTH) m_err = 1'b1;
    else
      for (int i = 0; i < WAYS; i++)
        if (l_ren[i]) begin
          hist[m_tail % HN] = l_rpr[i*PRW +: PRW];
          m_tail++;
        end
    if (l_save && !l_rec) m_slot[l_sid] = m_head + pops;
    if (l_rec) m_head = m_slot[l_rid];
    else m_head = m_head + pops;
    #1;
    idle_inputs();
  endtask

  task automatic cycle(input logic [WAYS-1:0] req, input logic [WAYS-1:0] ren,
                       input logic [WAYS*PRW-1:0] rpr);
    apply(req, ren, rpr, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
    check_out();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Checkpoint table from reset state: tags 32..63, count 32.
    tbl[0] = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 32, 32, 33};
    tbl[1] = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 30, 34, 35};
    tbl[2] = '{2'b00, 1'b1, 1'b0, 2, 1'b1, 28, -1, -1};
    tbl[3] = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 28, 36, 37};
    tbl[4] = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 26, 38, 39};
    tbl[5] = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 24, 40, 41};
    tbl[6] = '{2'b11, 1'b0, 1'b1, 2, 1'b0, 22, -1, -1};
    tbl[7] = '{2'b01, 1'b0, 1'b0, 0, 1'b1, 28, 36, -1};
    tbl[8] = '{2'b10, 1'b0, 1'b0, 0, 1'b1, 27, -1, 37};

    idle_inputs();
    do_reset();
    chk("rst_count", int'(fl.count), 32);
    chk("rst_full", int'(fl.full), 1);
    chk("rst_empty", int'(fl.empty), 0);
    chk("rst_almost_empty", int'(fl.almost_empty), 0);
    chk("rst_error", int'(fl.error), 0);
    chk("rst_ok_noreq", int'(fl.alloc_ok), 1);

    for (int r = 0; r < 9; r++) begin
      apply(tbl[r].req, '0, '0, tbl[r].save, tbl[r].id, tbl[r].rec, tbl[r].id);
      @(negedge clk);
      check_out();
      chk($sformatf("tbl%0d_ok", r), int'(fl.alloc_ok), int'(tbl[r].ok));
      chk($sformatf("tbl%0d_count", r), int'(fl.count), tbl[r].cnt);
      if (tbl[r].pr0 >= 0) chk($sformatf("tbl%0d_pr0", r), int'(fl.alloc_pr[PRW-1:0]), tbl[r].pr0);
      if (tbl[r].pr1 >= 0) chk($sformatf("tbl%0d_pr1", r), int'(fl.alloc_pr[2*PRW-1:PRW]), tbl[r].pr1);
      advance();
    end

    // Drain one lane at a time; then an empty list refuses and keeps its head.
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      apply(2'b01, '0, '0, 1'b0, 0, 1'b0, 0);
      #1;
      chk("t1_tag", int'(fl.alloc_pr[PRW-1:0]), NARCH + c);
      @(negedge clk);
      check_out();
      advance();
    end
    chk("t1_empty", int'(fl.empty), 1);
    chk("t1_almost_empty", int'(fl.almost_empty), 1);
    apply(2'b01, '0, '0, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t1_refuse", int'(fl.alloc_ok), 0);
    @(negedge clk);
    check_out();
    advance();
    chk("t1_count_hold", int'(fl.count), 0);

    // Refill two per cycle with tags 40, 41, ... (6-bit wrap past 63).
    for (int c = 0; c < DEPTH / 2; c++)
      cycle(2'b00, 2'b11, {PRW'(41 + 2*c), PRW'(40 + 2*c)});
    chk("t2_full", int'(fl.full), 1);
    chk("t2_count", int'(fl.count), 32);

    // Full list: pop two and retire 7,9 together.
    apply(2'b11, 2'b11, {PRW'(9), PRW'(7)}, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t3_ok", int'(fl.alloc_ok), 1);
    chk("t3_pr0", int'(fl.alloc_pr[PRW-1:0]), 40);
    chk("t3_pr1", int'(fl.alloc_pr[2*PRW-1:PRW]), 41);
    @(negedge clk);
    check_out();
    advance();
    chk("t3_count", int'(fl.count), 32);
    for (int c = 0; c < 15; c++) cycle(2'b11, '0, '0);
    apply(2'b11, '0, '0, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t3_wrap_pr0", int'(fl.alloc_pr[PRW-1:0]), 7);
    chk("t3_wrap_pr1", int'(fl.alloc_pr[2*PRW-1:PRW]), 9);
    @(negedge clk);
    check_out();
    advance();

    // One entry left: a two-lane request is refused whole, a single upper-lane request gets it.
    cycle(2'b00, 2'b01, {PRW'(0), PRW'(11)});
    chk("t4_count1", int'(fl.count), 1);
    apply(2'b11, '0, '0, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t4_refuse", int'(fl.alloc_ok), 0);
    @(negedge clk);
    check_out();
    advance();
    chk("t4_count_hold", int'(fl.count), 1);
    apply(2'b10, '0, '0, 1'b0, 0, 1'b0, 0);
    #1;
    chk("t4_lane1_ok", int'(fl.alloc_ok), 1);
    chk("t4_lane1_tag", int'(fl.alloc_pr[2*PRW-1:PRW]), 11);
    @(negedge clk);
    check_out();
    advance();
    chk("t4_count0", int'(fl.count), 0);

    // Overflow from the reset-full state: retire dropped, sticky error.
    do_reset();
    cycle(2'b00, 2'b01, {PRW'(0), PRW'(5)});
    chk("t6_error", int'(fl.error), 1);
    chk("t6_count", int'(fl.count), 32);
    cycle(2'b01, '0, '0);
    cycle(2'b00, '0, '0);
    chk("t6_error_sticky", int'(fl.error), 1);

    // Random traffic with saves (no recovery) against the reference list.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      apply(WAYS'($urandom), WAYS'($urandom), (WAYS*PRW)'($urandom),
            1'($urandom_range(0, 3) == 0), $urandom_range(0, NCKPT-1), 1'b0, 0);
      @(negedge clk);
      check_out();
      advance();
    end

    // Reset mid-operation with traffic on every input.
    fl.alloc_req = 2'b11; fl.retire_en = 2'b11; fl.retire_pr = {PRW'(3), PRW'(4)};
    fl.recover_en = 1'b1; fl.recover_id = CKW'(1);
    do_reset();
    chk("rst2_count", int'(fl.count), 32);
    chk("rst2_full", int'(fl.full), 1);
    chk("rst2_empty", int'(fl.empty), 0);
    chk("rst2_error", int'(fl.error), 0);
    apply(2'b01, '0, '0, 1'b0, 0, 1'b0, 0);
    #1;
    chk("rst2_first_tag", int'(fl.alloc_pr[PRW-1:0]), NARCH);
    @(negedge clk);
    check_out();
    advance();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
